// File: rtl/irrigation_zone_scheduler_if.sv
// Sensor inputs and actuator/status outputs of the irrigation zone scheduler.
// slave is the scheduler side; master is whoever drives the sensors.
interface irrigation_zone_scheduler_if #(
   parameter int ZONES = 4
);
   localparam int AZW = $clog2(ZONES);

   logic             low_water_level_i;
   logic             mid_water_level_i;
   logic             high_water_level_i;
   logic [ZONES-1:0] earth_humidity_i;
   logic             air_humidity_i;
   logic             low_temperature_i;
   logic             enable_i;
   logic             water_supply_valvule_o;
   logic             splinker_bomb_o;
   logic             dripper_valvule_o;
   logic [ZONES-1:0] zone_valvule_o;
   logic [AZW-1:0]   active_zone_o;
   logic [1:0]       state_o;
   logic             alarm_o;

   modport slave (
      input  low_water_level_i, mid_water_level_i, high_water_level_i, earth_humidity_i,
             air_humidity_i, low_temperature_i, enable_i,
      output water_supply_valvule_o, splinker_bomb_o, dripper_valvule_o, zone_valvule_o,
             active_zone_o, state_o, alarm_o
   );

   modport master (
      output low_water_level_i, mid_water_level_i, high_water_level_i, earth_humidity_i,
             air_humidity_i, low_temperature_i, enable_i,
      input  water_supply_valvule_o, splinker_bomb_o, dripper_valvule_o, zone_valvule_o,
             active_zone_o, state_o, alarm_o
   );
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// Multi-zone irrigation scheduler: debounced tank/soil sensors, round-robin service of
// dry zones with tick-timed RUN/REST, refill-valve hysteresis and level-conflict fault.
module irrigation_zone_scheduler #(
   parameter int ZONES      = 4,
   parameter int DEBOUNCE   = 8,
   parameter int TICK_DIV   = 1000,
   parameter int RUN_TICKS  = 16,
   parameter int REST_TICKS = 4
) (
   input logic                        clock_i,
   input logic                        reset_n_i,
   irrigation_zone_scheduler_if.slave bus
);
   localparam int AZW = $clog2(ZONES);
   localparam int NS  = ZONES + 3;
   localparam int DCW = $clog2(DEBOUNCE + 1);
   localparam int PCW = $clog2(TICK_DIV);
   localparam int TMX = (RUN_TICKS > REST_TICKS) ? RUN_TICKS : REST_TICKS;
   localparam int TW  = $clog2(TMX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_REST  = 2'b10,
      S_FAULT = 2'b11
   } state_e;

   // Sensor vector layout: bit0 L, bit1 M, bit2 H, bits 3.. earth per zone.
   logic [NS-1:0] raw, sync1_q, sync2_q, db;
   logic [2:0]    wx1_q, wx2_q;

   assign raw = {bus.earth_humidity_i, bus.high_water_level_i, bus.mid_water_level_i,
                 bus.low_water_level_i};

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         wx1_q   <= '0;
         wx2_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         wx1_q   <= {bus.enable_i, bus.low_temperature_i, bus.air_humidity_i};
         wx2_q   <= wx1_q;
      end
   end

   for (genvar g = 0; g < NS; g++) begin : g_deb
      logic [DCW-1:0] cnt_q;
      logic           bit_q;
      always_ff @(posedge clock_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            cnt_q <= '0;
            bit_q <= 1'b0;
         end else if (sync2_q[g] == bit_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DCW'(DEBOUNCE - 1)) begin
            cnt_q <= '0;
            bit_q <= sync2_q[g];
         end else begin
            cnt_q <= cnt_q + DCW'(1);
         end
      end
      assign db[g] = bit_q;
   end

   logic             lvl_l, lvl_m, lvl_h, conflict;
   logic             air_s, lowt_s, en_s;
   logic [ZONES-1:0] earth_db;

   assign lvl_l    = db[0];
   assign lvl_m    = db[1];
   assign lvl_h    = db[2];
   assign earth_db = db[NS-1:3];
   assign air_s    = wx2_q[0];
   assign lowt_s   = wx2_q[1];
   assign en_s     = wx2_q[2];
   assign conflict = (lvl_h & ~lvl_m) | (lvl_m & ~lvl_l) | (lvl_h & ~lvl_l);

   logic [PCW-1:0] pre_q;
   logic           tick;

   assign tick = (pre_q == PCW'(TICK_DIV - 1));

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) pre_q <= '0;
      else if (tick)  pre_q <= '0;
      else            pre_q <= pre_q + PCW'(1);
   end

   state_e         state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [AZW-1:0] rr_ptr_q, rr_ptr_d, zone_q, zone_d, sel;
   logic           mode_q, mode_d, found;

   // rr_ptr itself is searched last, so a lone dry zone keeps being served.
   always_comb begin : p_sel
      logic [AZW-1:0] idx;
      idx   = '0;
      sel   = rr_ptr_q;
      found = 1'b0;
      for (int k = 1; k <= ZONES; k++) begin
         idx = AZW'((int'(rr_ptr_q) + k) % ZONES);
         if (!found && !earth_db[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      rr_ptr_d = rr_ptr_q;
      zone_d   = zone_q;
      mode_d   = mode_q;
      case (state_q)
         S_IDLE: begin
            if (conflict) begin
               state_d = S_FAULT;
               timer_d = '0;
            end else if (en_s && lvl_l && found) begin
               state_d  = S_RUN;
               timer_d  = TW'(RUN_TICKS);
               rr_ptr_d = sel;
               zone_d   = sel;
               mode_d   = lvl_m & ~air_s & ~lowt_s;
            end
         end
         S_RUN: begin
            if (conflict) begin
               state_d = S_FAULT;
               timer_d = '0;
            end else if ((tick && timer_q == TW'(1)) || earth_db[zone_q] || !lvl_l || !en_s) begin
               state_d = S_REST;
               timer_d = TW'(REST_TICKS);
            end else if (tick) begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_REST: begin
            if (conflict) begin
               state_d = S_FAULT;
               timer_d = '0;
            end else if (tick) begin
               timer_d = timer_q - TW'(1);
               if (timer_q == TW'(1)) state_d = S_IDLE;
            end
         end
         default: begin
            timer_d = '0;
            if (!conflict) state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they move on the same edge as the FSM.
   logic [ZONES-1:0] valve_d, valve_q;
   logic             spr_d, spr_q, drip_d, drip_q, sup_d, sup_q, alarm_d, alarm_q;

   always_comb begin
      valve_d = '0;
      spr_d   = 1'b0;
      drip_d  = 1'b0;
      if (state_d == S_RUN) begin
         valve_d = ZONES'(1) << zone_d;
         spr_d   = mode_d;
         drip_d  = ~mode_d;
      end
      sup_d = sup_q;
      if (conflict)    sup_d = 1'b0;
      else if (!lvl_m) sup_d = 1'b1;
      else if (lvl_h)  sup_d = 1'b0;
      alarm_d = (state_d == S_FAULT) | conflict | ~lvl_m;
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         rr_ptr_q <= AZW'(ZONES - 1);
         zone_q   <= '0;
         mode_q   <= 1'b0;
         valve_q  <= '0;
         spr_q    <= 1'b0;
         drip_q   <= 1'b0;
         sup_q    <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         rr_ptr_q <= rr_ptr_d;
         zone_q   <= zone_d;
         mode_q   <= mode_d;
         valve_q  <= valve_d;
         spr_q    <= spr_d;
         drip_q   <= drip_d;
         sup_q    <= sup_d;
         alarm_q  <= alarm_d;
      end
   end

   assign bus.zone_valvule_o         = valve_q;
   assign bus.splinker_bomb_o        = spr_q;
   assign bus.dripper_valvule_o      = drip_q;
   assign bus.water_supply_valvule_o = sup_q;
   assign bus.alarm_o                = alarm_q;
   assign bus.active_zone_o          = zone_q;
   assign bus.state_o                = state_q;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Bench for irrigation_zone_scheduler: directed table/sequences plus random stimulus,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_irrigation_zone_scheduler;
   localparam int ZONES      = 4;
   localparam int DEBOUNCE   = 2;
   localparam int TICK_DIV   = 4;
   localparam int RUN_TICKS  = 3;
   localparam int REST_TICKS = 2;
   localparam int NS         = ZONES + 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   irrigation_zone_scheduler_if #(.ZONES(ZONES)) bus ();

   irrigation_zone_scheduler #(
      .ZONES(ZONES), .DEBOUNCE(DEBOUNCE), .TICK_DIV(TICK_DIV),
      .RUN_TICKS(RUN_TICKS), .REST_TICKS(REST_TICKS)
   ) dut (
      .clock_i  (clk),
      .reset_n_i(rst_n),
      .bus      (bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Sensors: raw -> two-stage sample history -> accepted after DEBOUNCE disagreeing clocks.
   int m_s1[NS], m_s2[NS], m_acc[NS], m_run[NS];
   int m_w1[3], m_w2[3];   // air, low_temp, enable
   int m_pre, m_left, m_state, m_az, m_ptr, m_mode;
   int m_valve, m_spr, m_drip, m_sup, m_alarm;

   task automatic m_reset();
      for (int i = 0; i < NS; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_acc[i] = 0; m_run[i] = 0;
      end
      for (int i = 0; i < 3; i++) begin m_w1[i] = 0; m_w2[i] = 0; end
      m_pre = 0; m_left = 0; m_state = 0; m_az = 0; m_ptr = ZONES - 1; m_mode = 0;
      m_valve = 0; m_spr = 0; m_drip = 0; m_sup = 0; m_alarm = 0;
   endtask

   task automatic m_step();
      int l, m, h, conf, tick, en, pick, nst;
      int raw[NS];
      l = m_acc[0]; m = m_acc[1]; h = m_acc[2];
      conf = ((h && !m) || (m && !l) || (h && !l)) ? 1 : 0;
      tick = (m_pre == TICK_DIV - 1) ? 1 : 0;
      en   = m_w2[2];
      nst  = m_state;
      case (m_state)
         0: if (conf) begin nst = 3; m_left = 0; end
            else begin
               pick = -1;
               for (int k = 1; k <= ZONES; k++)
                  if (pick < 0 && m_acc[3 + (m_ptr + k) % ZONES] == 0) pick = (m_ptr + k) % ZONES;
               if (en && l && pick >= 0) begin
                  nst = 1; m_ptr = pick; m_az = pick; m_left = RUN_TICKS;
                  m_mode = (m && !m_w2[0] && !m_w2[1]) ? 1 : 0;
               end
            end
         1: if (conf) begin nst = 3; m_left = 0; end
            else if ((tick && m_left == 1) || m_acc[3 + m_az] || !l || !en) begin
               nst = 2; m_left = REST_TICKS;
            end else if (tick) m_left--;
         2: if (conf) begin nst = 3; m_left = 0; end
            else if (tick) begin
               if (m_left == 1) nst = 0;
               m_left--;
            end
         default: begin m_left = 0; if (!conf) nst = 0; end
      endcase
      m_state = nst;
      m_valve = (nst == 1) ? (1 << m_az) : 0;
      m_spr   = (nst == 1 && m_mode) ? 1 : 0;
      m_drip  = (nst == 1 && !m_mode) ? 1 : 0;
      if (conf) m_sup = 0;
      else if (!m) m_sup = 1;
      else if (h) m_sup = 0;
      m_alarm = (nst == 3 || conf || !m) ? 1 : 0;

      raw[0] = bus.low_water_level_i; raw[1] = bus.mid_water_level_i;
      raw[2] = bus.high_water_level_i;
      for (int z = 0; z < ZONES; z++) raw[3 + z] = bus.earth_humidity_i[z];
      for (int i = 0; i < NS; i++) begin
         if (m_s2[i] == m_acc[i]) m_run[i] = 0;
         else begin
            m_run[i]++;
            if (m_run[i] >= DEBOUNCE) begin m_acc[i] = m_s2[i]; m_run[i] = 0; end
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
      end
      for (int i = 0; i < 3; i++) m_w2[i] = m_w1[i];
      m_w1[0] = bus.air_humidity_i; m_w1[1] = bus.low_temperature_i; m_w1[2] = bus.enable_i;
      m_pre = (m_pre + 1) % TICK_DIV;
   endtask

   // One clock: model advances on the rising edge, DUT compared on the falling edge.
   task automatic step();
      int act, exp;
      @(posedge clk);
      if (!rst_n) m_reset(); else m_step();
      @(negedge clk);
      act = int'({bus.state_o, bus.zone_valvule_o, bus.splinker_bomb_o, bus.dripper_valvule_o,
                  bus.water_supply_valvule_o, bus.alarm_o, bus.active_zone_o});
      exp = (m_state << 10) | (m_valve << 6) | (m_spr << 5) | (m_drip << 4) |
            (m_sup << 3) | (m_alarm << 2) | m_az;
      chk("model", act, exp);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_state(input int st, input int maxc, input string nm, output int n);
      n = 0;
      while (int'(bus.state_o) != st && n < maxc) begin step(); n++; end
      chk(nm, int'(bus.state_o), st);
   endtask

   task automatic set_lvl(input bit l, input bit m, input bit h);
      bus.low_water_level_i  = l;
      bus.mid_water_level_i  = m;
      bus.high_water_level_i = h;
   endtask

   typedef struct {
      bit l, m, h;
      int sup, al, st;
   } hrow_t;

   hrow_t tbl[8];
   int    n, mx;

   initial begin
      tbl[0] = '{1, 0, 0, 1, 1, 0};
      tbl[1] = '{1, 1, 0, 1, 0, 0};
      tbl[2] = '{1, 1, 1, 0, 0, 0};
      tbl[3] = '{1, 1, 0, 0, 0, 0};
      tbl[4] = '{1, 0, 0, 1, 1, 0};
      tbl[5] = '{0, 0, 0, 1, 1, 0};
      tbl[6] = '{0, 1, 0, 0, 1, 3};
      tbl[7] = '{1, 1, 0, 0, 0, 0};

      m_reset();
      set_lvl(0, 0, 0);
      bus.earth_humidity_i = '0;
      bus.air_humidity_i = 0; bus.low_temperature_i = 0; bus.enable_i = 0;

      // reset state
      steps(3);
      chk("rst_state", bus.state_o, 0);
      chk("rst_zone", bus.zone_valvule_o, 0);
      chk("rst_spr", bus.splinker_bomb_o, 0);
      chk("rst_drip", bus.dripper_valvule_o, 0);
      chk("rst_sup", bus.water_supply_valvule_o, 0);
      chk("rst_alarm", bus.alarm_o, 0);
      chk("rst_az", bus.active_zone_o, 0);
      set_lvl(1, 1, 1);
      bus.earth_humidity_i = 4'b1111;
      bus.enable_i = 1;
      rst_n = 1'b1;
      steps(12);
      chk("rel_state", bus.state_o, 0);
      chk("rel_sup", bus.water_supply_valvule_o, 0);
      chk("rel_alarm", bus.alarm_o, 0);

      // round robin over zones 1 and 3
      set_lvl(1, 1, 0);
      bus.earth_humidity_i = 4'b0101;
      wait_state(1, 40, "rr_run1", n);
      chk("rr_valve1", bus.zone_valvule_o, 4'b0010);
      chk("rr_spr1", bus.splinker_bomb_o, 1);
      chk("rr_az1", bus.active_zone_o, 1);
      wait_state(2, 20, "rr_rest1", n);
      chk("rr_run1_len_ok", (n >= 9 && n <= 12) ? 1 : 0, 1);
      wait_state(0, 20, "rr_idle1", n);
      chk("rr_rest1_len", n, 8);
      wait_state(1, 5, "rr_run2", n);
      chk("rr_idle_len", n, 1);
      chk("rr_valve2", bus.zone_valvule_o, 4'b1000);
      chk("rr_az2", bus.active_zone_o, 3);
      wait_state(2, 20, "rr_rest2", n);
      chk("rr_run2_len", n, 11);
      wait_state(0, 20, "rr_idle2", n);
      wait_state(1, 5, "rr_run3", n);
      chk("rr_valve3", bus.zone_valvule_o, 4'b0010);

      // early exit in dripper mode on zone 2
      bus.earth_humidity_i = 4'b1111;
      wait_state(0, 40, "ee_idle", n);
      bus.air_humidity_i = 1;
      bus.earth_humidity_i = 4'b1011;
      wait_state(1, 40, "ee_run", n);
      chk("ee_valve", bus.zone_valvule_o, 4'b0100);
      chk("ee_drip", bus.dripper_valvule_o, 1);
      chk("ee_spr", bus.splinker_bomb_o, 0);
      steps(2);
      bus.earth_humidity_i = 4'b1111;
      wait_state(2, 20, "ee_rest", n);
      chk("ee_latency", n, 2 + DEBOUNCE + 1);
      chk("ee_drip_off", bus.dripper_valvule_o, 0);

      // level conflict during RUN
      wait_state(0, 40, "ft_idle", n);
      bus.earth_humidity_i = 4'b1011;
      wait_state(1, 40, "ft_run", n);
      set_lvl(1, 0, 1);
      steps(8);
      chk("ft_state", bus.state_o, 3);
      chk("ft_valve", bus.zone_valvule_o, 0);
      chk("ft_drip", bus.dripper_valvule_o, 0);
      chk("ft_spr", bus.splinker_bomb_o, 0);
      chk("ft_alarm", bus.alarm_o, 1);
      set_lvl(1, 1, 0);
      bus.earth_humidity_i = 4'b1111;
      wait_state(0, 20, "ft_recover", n);
      chk("ft_alarm_clr", bus.alarm_o, 0);
      set_lvl(1, 0, 0);
      steps(6);
      chk("ft_alarm_m", bus.alarm_o, 1);

      // hysteresis sweep table
      for (int i = 0; i < 8; i++) begin
         set_lvl(tbl[i].l, tbl[i].m, tbl[i].h);
         steps(8);
         chk($sformatf("hys%0d_sup", i), bus.water_supply_valvule_o, tbl[i].sup);
         chk($sformatf("hys%0d_alarm", i), bus.alarm_o, tbl[i].al);
         chk($sformatf("hys%0d_state", i), bus.state_o, tbl[i].st);
      end

      // one-clock dry glitch on zone 0
      bus.earth_humidity_i = 4'b1110;
      step();
      bus.earth_humidity_i = 4'b1111;
      mx = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (int'(bus.state_o) > mx) mx = int'(bus.state_o);
      end
      chk("glitch_state", mx, 0);

      // asynchronous reset in the middle of RUN
      bus.earth_humidity_i = 4'b1110;
      wait_state(1, 40, "ar_run", n);
      #1 rst_n = 1'b0;
      m_reset();
      #1;
      chk("ar_valve", bus.zone_valvule_o, 0);
      chk("ar_spr", bus.splinker_bomb_o, 0);
      chk("ar_drip", bus.dripper_valvule_o, 0);
      chk("ar_state", bus.state_o, 0);
      step();
      rst_n = 1'b1;

      // random stimulus against the model
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 5) begin
            case ($urandom_range(0, 4))
               0: set_lvl(0, 0, 0);
               1: set_lvl(1, 0, 0);
               2: set_lvl(1, 1, 0);
               3: set_lvl(1, 1, 1);
               default: set_lvl(1'($urandom), 1'($urandom), 1'($urandom));
            endcase
         end else if (r < 15) begin
            int z;
            z = $urandom_range(0, ZONES - 1);
            bus.earth_humidity_i[z] = ~bus.earth_humidity_i[z];
         end else if (r < 17) bus.air_humidity_i = ~bus.air_humidity_i;
         else if (r < 19) bus.low_temperature_i = ~bus.low_temperature_i;
         else if (r < 20) bus.enable_i = ~bus.enable_i;
         else if (r < 21) bus.enable_i = 1;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/irrigation_zone_scheduler.md
# irrigation_zone_scheduler

Multi-zone successor to the single-bed irrigation control path. It reads the shared tank level sensors and one soil-humidity sensor per zone, debounces them, and serves dry zones one at a time in round-robin order. For each zone it drives sprinkler or dripper for a bounded, tick-timed run, followed by a rest period. It also owns water-supply valve hysteresis, sensor-conflict fault handling and the alarm, and exports state for the display path.

## Interface
- ZONES, 4: number of irrigation zones, ≥2.
- DEBOUNCE, 8: consecutive clocks a synchronised sensor must hold a new value before it is accepted, ≥1.
- TICK_DIV, 1000: clocks per timer tick, ≥2.
- RUN_TICKS, 16: maximum irrigation ticks per zone visit, ≥1.
- REST_TICKS, 4: idle ticks after every run, ≥1.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- low_water_level, mid_water_level, high_water_level  in  1 each  tank level probes, 1 = water present.
- earth_humidity  in  ZONES  per-zone soil sensor, 1 = wet, 0 = dry (requests water).
- air_humidity, low_temperature  in  1 each  weather inputs.
- enable  in  1  global irrigation permit.
- water_supply_valvule  out  1  tank refill valve.
- splinker_bomb, dripper_valvule  out  1 each  irrigation actuators.
- zone_valvule  out  ZONES  one-hot zone valve, all-zero when not irrigating.
- active_zone  out  $clog2(ZONES)  index of last/current served zone.
- state  out  2  00 IDLE, 01 RUN, 10 REST, 11 FAULT.
- alarm  out  1  alarm LED drive.

## Operation
- Every level and earth_humidity bit passes through a 2-FF synchroniser, then a debounce counter. The debounced bit toggles once the synchronised value has differed from it for DEBOUNCE consecutive clocks. The counter clears whenever the values agree. air_humidity, low_temperature and enable are synchronised only.
- Conflict = (H & !M) | (M & !L) | (H & !L) on debounced levels.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick is high for one clock when count = TICK_DIV-1.
- IDLE: conflict -> FAULT. Otherwise, if enable, debounced L = 1 and any debounced earth bit = 0 -> RUN. The zone is the first dry zone searching upward from rr_ptr+1, wrapping modulo ZONES.
- On entering RUN: load rr_ptr/active_zone with the selected zone and load the timer with RUN_TICKS. Latch the mode: sprinkler if M & !air_humidity & !low_temperature, else dripper.
- RUN: the timer decrements on tick. Go to REST on the edge where any of the following holds:
  - the timer is 1 and tick is high;
  - the served zone's debounced earth bit is 1;
  - debounced L is 0;
  - enable is 0.
  Conflict -> FAULT, with priority over all other exits.
- REST: load the timer with REST_TICKS. Go to IDLE when the timer is 1 and tick is high. Conflict -> FAULT.
- FAULT: leave to IDLE on the edge where conflict is 0. The timer is cleared; rr_ptr is kept.
- Outputs in RUN: zone_valvule = one-hot(active_zone). splinker_bomb = mode; dripper_valvule = !mode. All three are 0 in every other state.
- water_supply_valvule:
  - set when debounced M = 0 and no conflict;
  - cleared when debounced H = 1 or conflict;
  - otherwise holds (hysteresis between M and H).
- alarm = (state = FAULT) | conflict | !debounced M.
- Reset values:
  - state IDLE, all outputs 0, active_zone 0;
  - rr_ptr ZONES-1, so zone 0 is searched first;
  - debounced sensors 0, prescaler 0, timer 0.

## Timing
- All outputs are registered and change on the same edge the FSM enters the corresponding state. There is no combinational input-to-output path.
- Sensor latency: a raw change stable from edge t is accepted at edge t+2+DEBOUNCE. Decisions using it follow one edge later.
- IDLE -> RUN takes one clock once its conditions hold.
- A full RUN lasts RUN_TICKS ticks. The first tick may be partial because the prescaler free-runs and is not reset on RUN entry.
- Simultaneous events in RUN: conflict beats REST. Multiple REST causes collapse into one transition.
- Assertion of reset_n low mid-RUN clears all actuators immediately (asynchronously).
- Zone selection wraps from ZONES-1 to 0. A zone that is dry alone is served repeatedly, with REST between visits.

## Test plan
Bench parameters: ZONES=4, DEBOUNCE=2, TICK_DIV=4, RUN_TICKS=3, REST_TICKS=2.

- Reset check: hold reset_n low, all inputs 0 -> all outputs 0, state 00, active_zone 0. Release with L=M=H=1, all zones wet -> state stays 00, supply valve 0, alarm 0.
- Round-robin service: L=M=1, H=0, air_humidity=0, low_temperature=0, zones 1 and 3 dry -> RUN zone 1 (zone_valvule=0010, splinker_bomb=1) for 3 ticks, then REST 2 ticks. Next RUN is zone 3 (1000), then zone 1 again.
- Early exit: dripper mode (air_humidity=1) on zone 2; zone 2 goes wet mid-run -> REST 2+DEBOUNCE+1 clocks after the raw change. dripper_valvule drops on that edge.
- Fault: during RUN set H=1, M=0 for ≥4 clocks -> state 11, all actuators 0, alarm 1. Restore consistent levels -> IDLE, alarm follows M.
- Hysteresis: sweep level L -> L+M -> L+M+H -> L+M -> L:
  - supply valve is 1 until H is accepted;
  - it stays 0 while M=1;
  - it reopens when M drops.
- Glitch rejection: a 1-clock pulse on earth_humidity[0] -> no state change. Async reset asserted mid-RUN -> outputs 0 before the next clock edge.
